// File: rtl/data_cache_pkg.sv
// Shared types and byte-lane helpers for the set-associative write-through data cache.
package data_cache_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } width_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REFILL    = 2'd1,
        WRITETHRU = 2'd2
    } state_e;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] w, input logic [1:0] off);
        return (w == 2'd3) || (w == HALF && off[0]) || (w == WORD && off != 2'b00);
    endfunction

    function automatic logic [3:0] lane_strobe(input logic [1:0] w, input logic [1:0] off);
        case (w)
            BYTE:    return 4'b0001 << off;
            HALF:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_shift(input logic [31:0] d, input logic [1:0] w,
                                               input logic [1:0] off);
        logic [31:0] masked;
        case (w)
            BYTE:    masked = {24'h0, d[7:0]};
            HALF:    masked = {16'h0, d[15:0]};
            default: masked = d;
        endcase
        return masked << {off, 3'b000};
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] w,
                                                 input logic [1:0] off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (w)
            BYTE:    return {24'h0, sh[7:0]};
            HALF:    return {16'h0, sh[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/data_cache_way.sv
// One cache way: tag, valid and data arrays; asynchronous read, byte-strobed write.
module data_cache_way
    import data_cache_pkg::*;
#(
    parameter int SETS  = 128,
    parameter int WORDS = 16,
    parameter int TAG_W = 19,
    parameter int IDX_W = 7
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [IDX_W-1:0]            rd_index,
    input  logic [width_of(WORDS)-1:0]  rd_word,
    output logic [TAG_W-1:0]            rd_tag,
    output logic                        rd_valid,
    output logic [31:0]                 rd_data,
    input  logic [IDX_W-1:0]            wr_index,
    input  logic [width_of(WORDS)-1:0]  wr_word,
    input  logic                        wr_en,
    input  logic [3:0]                  wr_strb,
    input  logic [31:0]                 wr_data,
    input  logic                        valid_clr,
    input  logic                        valid_set,
    input  logic [TAG_W-1:0]            tag_in
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS][WORDS];

    assign rd_tag   = tag_q[rd_index];
    assign rd_valid = valid_q[rd_index];
    assign rd_data  = data_q[rd_index][rd_word];

    always_ff @(posedge Clock) begin
        if (Reset)
            valid_q <= '0;
        else if (valid_clr)
            valid_q[wr_index] <= 1'b0;
        else if (valid_set)
            valid_q[wr_index] <= 1'b1;
    end

    // Data and tags need no reset: nothing is visible until its valid bit is set.
    always_ff @(posedge Clock) begin
        if (valid_set)
            tag_q[wr_index] <= tag_in;
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b])
                    data_q[wr_index][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/data_cache_sa.sv
// N-way set-associative write-through, read-allocate data cache with burst refill.
// IDLE: lookup/accept | REFILL: burst into victim way | WRITETHRU: wait for store ack
module data_cache_sa
    import data_cache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 128,
    parameter int LINE_BYTES = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReadEnable,
    input  logic                  WriteEnable,
    input  logic [1:0]            DataWidth,
    input  logic [ADDR_WIDTH-1:0] DataAddress,
    input  logic [31:0]           DataFromCore,
    output logic [31:0]           DataToCore,
    output logic                  ReadComplete,
    output logic                  WriteComplete,
    output logic                  AccessFault,
    output logic                  MemReadReq,
    output logic                  MemWriteReq,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [31:0]           MemWriteData,
    output logic [3:0]            MemWriteStrobe,
    input  logic [31:0]           MemReadData,
    input  logic                  MemReadValid,
    input  logic                  MemWriteAck
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
    localparam int WORDS  = LINE_BYTES / 4;
    localparam int BEAT_W = width_of(WORDS);
    localparam int WAY_W  = width_of(WAYS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

    logic [TAG_W-1:0]  addr_tag;
    logic [IDX_W-1:0]  addr_index;
    logic [BEAT_W-1:0] addr_word;
    logic [1:0]        addr_off;
    logic [ADDR_WIDTH-1:0] line_base;
    logic [31:0]       store_lane;
    logic [3:0]        store_strb;

    assign addr_tag   = DataAddress[ADDR_WIDTH-1 -: TAG_W];
    assign addr_index = DataAddress[OFF_W +: IDX_W];
    assign addr_word  = DataAddress[2 +: BEAT_W];
    assign addr_off   = DataAddress[1:0];
    assign line_base  = {addr_tag, addr_index, {OFF_W{1'b0}}};
    assign store_lane = lane_shift(DataFromCore, DataWidth, addr_off);
    assign store_strb = lane_strobe(DataWidth, addr_off);

    logic [TAG_W-1:0] way_tag  [WAYS];
    logic [31:0]      way_data [WAYS];
    logic [WAYS-1:0]  way_valid;

    logic [IDX_W-1:0]  arr_index;
    logic [BEAT_W-1:0] arr_word;
    logic [31:0]       arr_data;
    logic [3:0]        arr_strb;
    logic [WAYS-1:0]   arr_we, arr_clr, arr_set;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WAY_W-1:0]  miss_way_q, miss_way_d;
    logic [IDX_W-1:0]  miss_index_q, miss_index_d;
    logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
    logic [WAY_W-1:0]  rr_q [SETS];
    logic [WAY_W-1:0]  rr_next;
    logic              rr_adv;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        data_cache_way #(
            .SETS  (SETS),
            .WORDS (WORDS),
            .TAG_W (TAG_W),
            .IDX_W (IDX_W)
        ) u_way (
            .Clock     (Clock),
            .Reset     (Reset),
            .rd_index  (addr_index),
            .rd_word   (addr_word),
            .rd_tag    (way_tag[w]),
            .rd_valid  (way_valid[w]),
            .rd_data   (way_data[w]),
            .wr_index  (arr_index),
            .wr_word   (arr_word),
            .wr_en     (arr_we[w]),
            .wr_strb   (arr_strb),
            .wr_data   (arr_data),
            .valid_clr (arr_clr[w]),
            .valid_set (arr_set[w]),
            .tag_in    (miss_tag_q)
        );
    end

    logic             hit, found_inv;
    logic [WAYS-1:0]  hit_vec;
    logic [WAY_W-1:0] hit_way, victim;

    // Victim prefers the lowest invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        hit       = 1'b0;
        hit_vec   = '0;
        hit_way   = '0;
        found_inv = 1'b0;
        victim    = rr_q[addr_index];
        for (int w = 0; w < WAYS; w++) begin
            if (way_valid[w] && way_tag[w] == addr_tag) begin
                hit_vec[w] = 1'b1;
                if (!hit) begin
                    hit     = 1'b1;
                    hit_way = WAY_W'(w);
                end
            end
            if (!way_valid[w] && !found_inv) begin
                found_inv = 1'b1;
                victim    = WAY_W'(w);
            end
        end
    end

    assign rr_next = (rr_q[addr_index] == WAY_W'(WAYS - 1)) ? '0 : rr_q[addr_index] + 1'b1;

    logic                  pulse_any;
    logic                  read_done_d, write_done_d, fault_d;
    logic                  mem_rreq_d, mem_wreq_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [31:0]           mem_wdata_d, data_to_core_d;
    logic [3:0]            mem_strb_d;

    assign pulse_any = ReadComplete | WriteComplete | AccessFault;

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        miss_way_d     = miss_way_q;
        miss_index_d   = miss_index_q;
        miss_tag_d     = miss_tag_q;
        read_done_d    = 1'b0;
        write_done_d   = 1'b0;
        fault_d        = 1'b0;
        data_to_core_d = DataToCore;
        mem_rreq_d     = MemReadReq;
        mem_wreq_d     = MemWriteReq;
        mem_addr_d     = MemAddr;
        mem_wdata_d    = MemWriteData;
        mem_strb_d     = MemWriteStrobe;
        arr_index      = addr_index;
        arr_word       = addr_word;
        arr_data       = store_lane;
        arr_strb       = store_strb;
        arr_we         = '0;
        arr_clr        = '0;
        arr_set        = '0;
        rr_adv         = 1'b0;
        case (state_q)
            IDLE: begin
                if ((ReadEnable || WriteEnable) && !pulse_any) begin
                    if (is_misaligned(DataWidth, addr_off)) begin
                        fault_d = 1'b1;
                    end else if (WriteEnable) begin
                        if (hit)
                            arr_we = hit_vec;
                        state_d     = WRITETHRU;
                        mem_wreq_d  = 1'b1;
                        mem_addr_d  = {DataAddress[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_d = store_lane;
                        mem_strb_d  = store_strb;
                    end else if (hit) begin
                        read_done_d    = 1'b1;
                        data_to_core_d = lane_extract(way_data[hit_way], DataWidth, addr_off);
                    end else begin
                        miss_way_d      = victim;
                        miss_index_d    = addr_index;
                        miss_tag_d      = addr_tag;
                        arr_clr[victim] = 1'b1;
                        rr_adv          = 1'b1;
                        beat_d          = '0;
                        state_d         = REFILL;
                        mem_rreq_d      = 1'b1;
                        mem_addr_d      = line_base;
                    end
                end
            end
            REFILL: begin
                arr_index = miss_index_q;
                arr_word  = beat_q;
                arr_data  = MemReadData;
                arr_strb  = 4'hF;
                if (MemReadValid) begin
                    arr_we[miss_way_q] = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        arr_set[miss_way_q] = 1'b1;
                        beat_d     = '0;
                        mem_rreq_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            WRITETHRU: begin
                if (MemWriteAck) begin
                    mem_wreq_d   = 1'b0;
                    write_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q        <= IDLE;
            beat_q         <= '0;
            miss_way_q     <= '0;
            miss_index_q   <= '0;
            miss_tag_q     <= '0;
            ReadComplete   <= 1'b0;
            WriteComplete  <= 1'b0;
            AccessFault    <= 1'b0;
            DataToCore     <= '0;
            MemReadReq     <= 1'b0;
            MemWriteReq    <= 1'b0;
            MemAddr        <= '0;
            MemWriteData   <= '0;
            MemWriteStrobe <= '0;
            for (int s = 0; s < SETS; s++)
                rr_q[s] <= '0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            miss_way_q     <= miss_way_d;
            miss_index_q   <= miss_index_d;
            miss_tag_q     <= miss_tag_d;
            ReadComplete   <= read_done_d;
            WriteComplete  <= write_done_d;
            AccessFault    <= fault_d;
            DataToCore     <= data_to_core_d;
            MemReadReq     <= mem_rreq_d;
            MemWriteReq    <= mem_wreq_d;
            MemAddr        <= mem_addr_d;
            MemWriteData   <= mem_wdata_d;
            MemWriteStrobe <= mem_strb_d;
            if (rr_adv)
                rr_q[addr_index] <= rr_next;
        end
    end

endmodule

// File: doc/data_cache_sa.md
# data_cache_sa

Parametrised N-way set-associative, write-through, read-allocate, no-write-allocate data cache between the core load/store unit and the memory bus. Serves byte/half/word accesses, refills whole lines by burst on read miss, and forwards every store to memory with a byte strobe. Generalises the fixed 2-way/128-set cache to configurable ways, sets and line size, and adds a real refill path, write-through, replacement and alignment checking.

## Interface
- WAYS, 2: associativity; power of two, 1..8.
- SETS, 128: sets per way; power of two.
- LINE_BYTES, 64: bytes per line; power of two, ≥4.
- ADDR_WIDTH, 32: address width; TAG_W = ADDR_WIDTH − log2(SETS) − log2(LINE_BYTES).
- Clock  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- ReadEnable / WriteEnable  in  1  access request; held by core until Complete or AccessFault.
- DataWidth  in  2  0 byte, 1 half, 2 word, 3 illegal.
- DataAddress  in  ADDR_WIDTH  byte address.
- DataFromCore  in  32  store data, right-aligned.
- DataToCore  out  32  load data, zero-extended; holds until next ReadComplete.
- ReadComplete / WriteComplete / AccessFault  out  1  single-cycle pulses.
- MemReadReq  out  1  burst read request, held until last beat.
- MemWriteReq  out  1  single-word write request, held until ack.
- MemAddr  out  ADDR_WIDTH  line base (read) or word-aligned address (write).
- MemWriteData  out  32  store data shifted to byte lane; MemWriteStrobe out 4.
- MemReadData  in  32; MemReadValid  in  1  one beat per assertion, LINE_BYTES/4 beats, ascending.
- MemWriteAck  in  1  write accepted.

## Operation
- States: IDLE, REFILL, WRITETHRU. Requests sampled only in IDLE when no pulse output is high.
- Both enables high: write performed, read ignored.
- Fault: DataWidth=3, half at odd address, word at address not multiple of 4 → AccessFault, no state/array change, no bus activity.
- Read hit (tag match in a valid way): bytes at offset assembled little-endian → DataToCore, ReadComplete.
- Read miss: victim = lowest-index invalid way, else per-set round-robin pointer; pointer advances (mod WAYS) on every refill of that set. Victim valid cleared at miss; REFILL writes beats into victim at beat counter; valid and tag set on last beat; → IDLE, held request re-looked-up (hits).
- Write: hit updates strobed bytes of hitting way only; miss leaves arrays untouched. Either way → WRITETHRU; WriteComplete after MemWriteAck; → IDLE.
- MemReadValid ignored outside REFILL; MemWriteAck ignored outside WRITETHRU.
- Reset: all valid bits, round-robin pointers, beat counter cleared; state IDLE; every output 0. Reset mid-refill abandons burst; victim line stays invalid. Memory side shares Reset.

## Timing
- Hit: request sampled edge t → pulse and data in cycle t+1.
- Read miss: MemReadReq and MemAddr from cycle t+1 through the cycle of last MemReadValid; low next cycle. Last beat cycle k → ReadComplete in k+2.
- Write: MemWriteReq from t+1 through ack cycle a; WriteComplete in a+1. Ack in t+1 allowed.
- Max throughput: one hit every 2 cycles.

## Structure
- Package data_cache_pkg: width enum (BYTE/HALF/WORD), state enum, derived width functions, lane-shift/strobe helper functions.
- Sub-module data_cache_way: one way's tag, valid and data arrays with byte-write port; instantiated WAYS times via generate.

## Test plan
- Reset, read word 0x1040; memory returns 0x10000000+i for beats 0..15 → MemAddr=0x1040, ReadComplete k+2, DataToCore=0x10000000; half read 0x1044 hits in 1 cycle → 0x00000001, no MemReadReq.
- Byte read 0x1047 → 0x00000010; word read 0x1042 → AccessFault only, no bus activity.
- Word write 0xDEADBEEF to 0x1048, ack after 3 cycles → strobe 1111, WriteComplete cycle after ack; read 0x1048 hits → 0xDEADBEEF. Byte write 0xAB to 0x1049 → strobe 0010, MemWriteData 0x0000AB00.
- Write miss 0x9000 → bus write, then read 0x9000 misses (no allocate).
- Read 0x1040, 0x3040, 0x5040 (set 65) → 0x5040 evicts way 0; re-read 0x1040 misses and evicts way 1 (0x3040).
- Reset after 5 refill beats → next cycle MemReadReq=0, outputs 0; read 0x1040 misses.
